// File: rtl/ex_mdu_seq.sv
// Iterative RV64M multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, with a valid/ready front end and a held registered result.
module ex_mdu_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] hi_q, hi_d;
  logic [63:0] lo_q, lo_d;
  logic [63:0] opb_q, opb_d;
  logic [63:0] result_q, result_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        is_mul_q, is_mul_d;
  logic        is_w_q, is_w_d;
  logic        is_rem_q, is_rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        out_valid_q, busy_q;

  logic dec_valid, dec_mul, dec_w, dec_signed, dec_rem;

  always_comb begin
    dec_valid  = 1'b1;
    dec_mul    = 1'b0;
    dec_w      = 1'b0;
    dec_signed = 1'b0;
    dec_rem    = 1'b0;
    case (op)
      4'd0: begin dec_mul = 1'b1; dec_signed = 1'b1; end
      4'd1: begin dec_mul = 1'b1; dec_signed = 1'b1; dec_w = 1'b1; end
      4'd2: dec_signed = 1'b1;
      4'd3: ;
      4'd4: begin dec_signed = 1'b1; dec_rem = 1'b1; end
      4'd5: dec_rem = 1'b1;
      4'd6: begin dec_w = 1'b1; dec_signed = 1'b1; end
      4'd7: dec_w = 1'b1;
      4'd8: begin dec_w = 1'b1; dec_signed = 1'b1; dec_rem = 1'b1; end
      4'd9: begin dec_w = 1'b1; dec_rem = 1'b1; end
      default: dec_valid = 1'b0;
    endcase
  end

  logic        a_neg, b_neg, div_zero, div_ovf, special;
  logic [31:0] a_lo_neg, b_lo_neg;
  logic [63:0] a_mag, b_mag, a_sext, spec_res;

  always_comb begin
    a_sext   = {{32{a[31]}}, a[31:0]};
    a_neg    = dec_signed && (dec_w ? a[31] : a[63]);
    b_neg    = dec_signed && (dec_w ? b[31] : b[63]);
    a_lo_neg = -a[31:0];
    b_lo_neg = -b[31:0];
    if (dec_w) begin
      a_mag = a_neg ? {32'd0, a_lo_neg} : {32'd0, a[31:0]};
      b_mag = b_neg ? {32'd0, b_lo_neg} : {32'd0, b[31:0]};
    end else begin
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
    end
    div_zero = !dec_mul && (dec_w ? (b[31:0] == 32'd0) : (b == 64'd0));
    div_ovf  = !dec_mul && dec_signed &&
               (dec_w ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                      : ((a == 64'h8000_0000_0000_0000) && (b == {64{1'b1}})));
    special  = !dec_valid || div_zero || div_ovf;
    spec_res = 64'd0;
    if (dec_valid && div_zero) begin
      spec_res = dec_rem ? (dec_w ? a_sext : a) : {64{1'b1}};
    end else if (dec_valid && div_ovf) begin
      spec_res = dec_rem ? 64'd0 : (dec_w ? a_sext : a);
    end
  end

  // hi: product accumulator / partial remainder; lo: multiplier / dividend-then-quotient;
  // opb: multiplicand (shifts left) / divisor (fixed).
  logic [64:0] rem_sh, rem_diff;
  logic [63:0] hi_it, lo_it, opb_it, fin_mag, fin_val, fin_res;
  logic        fin_neg;

  always_comb begin
    rem_sh   = {hi_q, lo_q[63]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (is_mul_q) begin
      hi_it  = hi_q + (lo_q[0] ? opb_q : 64'd0);
      lo_it  = lo_q >> 1;
      opb_it = opb_q << 1;
    end else begin
      opb_it = opb_q;
      if (!rem_diff[64]) begin
        hi_it = rem_diff[63:0];
        lo_it = {lo_q[62:0], 1'b1};
      end else begin
        hi_it = rem_sh[63:0];
        lo_it = {lo_q[62:0], 1'b0};
      end
    end
    fin_neg = is_rem_q ? r_neg_q : q_neg_q;
    fin_mag = (is_mul_q || is_rem_q) ? hi_it : lo_it;
    fin_val = (!is_mul_q && fin_neg) ? -fin_mag : fin_mag;
    fin_res = is_w_q ? {{32{fin_val[31]}}, fin_val[31:0]} : fin_val;
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    is_w_d   = is_w_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          is_mul_d = dec_mul;
          is_w_d   = dec_w;
          is_rem_d = dec_rem;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          cnt_d    = dec_w ? 7'd32 : 7'd64;
          hi_d     = 64'd0;
          if (dec_mul) begin
            lo_d  = b;
            opb_d = a;
          end else begin
            // W dividends sit in the top half so the MSB-first shift sees them first.
            lo_d  = dec_w ? {a_mag[31:0], 32'd0} : a_mag;
            opb_d = b_mag;
          end
          if (special) begin
            state_d  = StDone;
            result_d = spec_res;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!flush) begin
          hi_d  = hi_it;
          lo_d  = lo_it;
          opb_d = opb_it;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_d  = StDone;
            result_d = fin_res;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      hi_q        <= 64'd0;
      lo_q        <= 64'd0;
      opb_q       <= 64'd0;
      result_q    <= 64'd0;
      cnt_q       <= 7'd0;
      is_mul_q    <= 1'b0;
      is_w_q      <= 1'b0;
      is_rem_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      is_mul_q    <= is_mul_d;
      is_w_q      <= is_w_d;
      is_rem_q    <= is_rem_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign in_ready  = (state_q == StIdle) && resetn;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Scoreboard bench for ex_mdu_seq: directed and random RV64M ops checked against
// a plain-arithmetic reference model, plus backpressure, flush and reset scenarios.
module tb_ex_mdu_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  always #5 clk = ~clk;

  ex_mdu_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [63:0] res;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the RV64M rules.
  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] x,
                                          input logic [63:0] y);
    longint      sx, sy;
    int          sx32, sy32;
    logic [31:0] ux32, uy32, r32;
    logic        ovf64, ovf32;
    sx = x;
    sy = y;
    ux32 = x[31:0];
    uy32 = y[31:0];
    sx32 = ux32;
    sy32 = uy32;
    ovf64 = (x == 64'h8000_0000_0000_0000) && (y == {64{1'b1}});
    ovf32 = (ux32 == 32'h8000_0000) && (uy32 == 32'hFFFF_FFFF);
    r32 = 32'd0;
    case (o)
      4'd0: return x * y;
      4'd1: r32 = ux32 * uy32;
      4'd2: begin
        if (y == 64'd0) return {64{1'b1}};
        if (ovf64) return x;
        return 64'(sx / sy);
      end
      4'd3: begin
        if (y == 64'd0) return {64{1'b1}};
        return x / y;
      end
      4'd4: begin
        if (y == 64'd0) return x;
        if (ovf64) return 64'd0;
        return 64'(sx % sy);
      end
      4'd5: begin
        if (y == 64'd0) return x;
        return x % y;
      end
      4'd6: begin
        if (uy32 == 32'd0) r32 = {32{1'b1}};
        else if (ovf32) r32 = 32'h8000_0000;
        else r32 = 32'(sx32 / sy32);
      end
      4'd7: begin
        if (uy32 == 32'd0) r32 = {32{1'b1}};
        else r32 = ux32 / uy32;
      end
      4'd8: begin
        if (uy32 == 32'd0) r32 = ux32;
        else if (ovf32) r32 = 32'd0;
        else r32 = 32'(sx32 % sy32);
      end
      4'd9: begin
        if (uy32 == 32'd0) r32 = ux32;
        else r32 = ux32 % uy32;
      end
      default: return 64'd0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic bit is_special(input logic [3:0] o, input logic [63:0] x,
                                    input logic [63:0] y);
    bit w, zero, sgn, ovf;
    if (o > 4'd9) return 1'b1;
    if (o < 4'd2) return 1'b0;
    w    = (o >= 4'd6);
    zero = w ? (y[31:0] == 32'd0) : (y == 64'd0);
    sgn  = (o == 4'd2) || (o == 4'd4) || (o == 4'd6) || (o == 4'd8);
    ovf  = w ? ((x[31:0] == 32'h8000_0000) && (y[31:0] == 32'hFFFF_FFFF))
             : ((x == 64'h8000_0000_0000_0000) && (y == {64{1'b1}}));
    return zero || (sgn && ovf);
  endfunction

  function automatic int n_iter(input logic [3:0] o);
    return ((o == 4'd1) || (o >= 4'd6)) ? 32 : 64;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return 64'd1;
      2: return {64{1'b1}};
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'h0000_0000_FFFF_FFFF;
      6: return 64'($urandom_range(0, 1000));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       input bit track);
    int   waitn;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    waitn = 0;
    while (!in_ready && waitn < 400) begin
      @(negedge clk);
      waitn++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready got 0 after %0d cycles, expected 1", waitn);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (track) begin
      e.res = ref_res(o, x, y);
      e.done_cyc = cyc + (is_special(o, x, y) ? 0 : n_iter(o));
      sb_q.push_back(e);
    end
    in_valid = 1'b0;
    op = 4'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, busy=%b, expected 0 and 0",
               sb_q.size(), busy);
    end
  endtask

  initial begin : ready_driver
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // A handshake at edge k is seen at the sample after k as (valid before k) && out_ready.
  initial begin : monitor
    logic        prev_v;
    logic [63:0] held;
    int          first_cyc;
    exp_t        e;
    prev_v = 1'b0;
    held = 64'd0;
    first_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%h, expected no result", held);
          end else begin
            e = sb_q.pop_front();
            check("result", held, e.res);
            check("valid_cycle", 64'(first_cyc), 64'(e.done_cyc));
          end
          prev_v = 1'b0;
        end
        if (out_valid) begin
          if (!prev_v) first_cyc = cyc;
          else check("hold_stable", result, held);
          held = result;
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   count;
    bit   seen;
    logic [3:0] ro;

    rdy_mode = 1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check("reset_result", result, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_bit("idle_in_ready", in_ready, 1'b1);

    // MUL 3 * -5 with busy length observed, out_ready held high.
    issue(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    count = 0;
    while (busy && count < 200) begin
      count++;
      @(posedge clk);
      #1;
    end
    check("mul_busy_cycles", 64'(count), 64'd65);

    issue(4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(4'd3, 64'd7, 64'd2, 1'b1);
    issue(4'd5, 64'd7, 64'd2, 1'b1);
    issue(4'd3, 64'd5, 64'd0, 1'b1);
    issue(4'd5, 64'd5, 64'd0, 1'b1);
    issue(4'd2, 64'h8000_0000_0000_0000, {64{1'b1}}, 1'b1);
    issue(4'd4, 64'h8000_0000_0000_0000, {64{1'b1}}, 1'b1);
    issue(4'd12, 64'd9, 64'd3, 1'b1);
    issue(4'd6, 64'h0000_0001_8000_0000, {64{1'b1}}, 1'b1);
    issue(4'd1, 64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1);
    issue(4'd7, 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1);
    issue(4'd8, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1);
    issue(4'd0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_drain();

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      issue(ro, pick_operand(), pick_operand(), 1'b1);
    end
    wait_drain();

    // Backpressure: hold a special-case result in DONE while offering another op.
    rdy_mode = 0;
    issue(4'd3, 64'd5, 64'd0, 1'b1);
    check_bit("special_valid_next", out_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      op = 4'd0;
      a = 64'd11;
      b = 64'd13;
      check_bit("bp_in_ready", in_ready, 1'b0);
      check_bit("bp_out_valid", out_valid, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_bit("bp_idle_in_ready", in_ready, 1'b1);
    check_bit("bp_idle_busy", busy, 1'b0);
    issue(4'd3, 64'd7, 64'd2, 1'b1);
    check_bit("bp_next_accept", busy, 1'b1);
    wait_drain();

    // Flush at iteration 20 of a DIV.
    issue(4'd2, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check_bit("flush_in_ready", in_ready, 1'b1);
    check_bit("flush_busy", busy, 1'b0);
    check_bit("flush_out_valid", out_valid, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_bit("flush_no_valid", seen, 1'b0);

    // Flush in IDLE with in_valid high accepts nothing.
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    op = 4'd3;
    a = 64'd5;
    b = 64'd0;
    @(posedge clk);
    #1;
    check_bit("idle_flush_busy", busy, 1'b0);
    check_bit("idle_flush_out_valid", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;

    // Reset in the middle of RUN, then a normal MUL.
    issue(4'd0, 64'd5, 64'd6, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    check("midrst_result", result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue(4'd0, 64'd3, 64'd4, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mdu_seq.md
# ex_mdu_seq

Iterative multiply/divide sequencer for the execute stage. It accepts one RV64M operation through a valid/ready handshake and runs a shift-add multiplier or a restoring divider one bit per cycle. It holds the result until the pipeline consumes it, and drives `busy` so the execute stage stalls the single-cycle ALU path behind it. Flush from the pipeline control aborts any in-flight operation.

## Interface
Parameters:
- none (64-bit datapath fixed)

Ports:
- `clk`  in  1  sole clock. All state updates on its rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  an operation is offered.
- `in_ready`  out  1  block can accept; equals state==IDLE and `resetn` high.
- `op`  in  4  operation select:
  - 0 MUL, 1 MULW
  - 2 DIV, 3 DIVU, 4 REM, 5 REMU
  - 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW
  - 10–15 are invalid.
- `a`  in  64  rs1 operand.
- `b`  in  64  rs2 operand.
- `flush`  in  1  abort; has priority over every other input except reset.
- `out_valid`  out  1  `result` is valid (state==DONE).
- `out_ready`  in  1  consumer takes the result.
- `result`  out  64  final value, registered.
- `busy`  out  1  state != IDLE; used as the execute-stage stall.

## Operation
- **Accept.** The operation is accepted on an edge where `in_valid && in_ready && !flush`.
  - `op`, `a` and `b` are captured into internal registers.
  - After the accept edge, the inputs may change freely.
- **States.** IDLE, RUN, DONE.
  - IDLE→RUN: normal operation accepted.
  - IDLE→DONE: special case accepted.
  - RUN→DONE: iteration counter reaches zero.
  - DONE→IDLE: `out_valid && out_ready`.
  - Any state→IDLE: `flush`.
- **Iteration count N.** N=64 for 64-bit ops. N=32 for W ops, which use `a[31:0]` and `b[31:0]`.
- **Signed ops** (MUL, MULW, DIV, REM, DIVW, REMW):
  - Operands are converted to magnitudes at accept.
  - Quotient sign is sign(a) xor sign(b).
  - Remainder sign is sign(a).
  - The sign fix is applied when entering DONE.
- **MUL, MULW.** Result is the low 64 bits (MUL) or low 32 bits (MULW) of the product. Signedness does not affect the low bits.
- **W results.** All W-op results are sign-extended from bit 31, including unsigned W ops.
- **Special cases.** These resolve at the accept edge with no RUN:
  - Divide by zero (b, or `b[31:0]` for W, equal to 0): quotient = all ones (W: 0xFFFF_FFFF sign-extended). Remainder = a (W: sign-extended `a[31:0]`).
  - Signed overflow (64-bit: a = 0x8000_0000_0000_0000, b = −1; W: `a[31:0]` = 0x8000_0000, `b[31:0]` = 0xFFFF_FFFF):
    - quotient = a (W: 0xFFFF_FFFF_8000_0000);
    - remainder = 0.
  - Invalid `op`: result = 0.
- **Holding in DONE.** `result` stays stable for as long as state is DONE. `in_ready` is low in DONE, so no accept can happen in the same cycle as the result handshake.
- **Flush.** In-flight work is discarded. Next state is IDLE, and `out_valid` is low from the next cycle. A flush in IDLE with `in_valid` high accepts nothing.
- **Reset** (`resetn` low at an edge), from any state including mid-RUN:
  - state = IDLE, `out_valid` = 0, `busy` = 0, `result` = 0;
  - the counter and all internal registers are cleared;
  - `in_ready` = 0 while `resetn` is low.

## Timing
Let edge e be the accept edge.
- **Normal op.** The block is in RUN for the N cycles after e, performing one iteration per edge. It enters DONE at edge e+N, so `out_valid` is first high in the cycle after edge e+N.
- **Special case.** DONE is entered at edge e, so `out_valid` is high in the cycle after e.
- **Handshake.** A handshake at edge h returns the block to IDLE: `in_ready` is high and `busy` is low in the cycle after h. The minimum accept-to-accept spacing is N+2 edges (normal op) or 2 edges (special case).
- **`busy`** is high from the cycle after e until the handshake edge, inclusive of DONE.
- **Flush at edge f.** `busy` is low and `in_ready` is high in the cycle after f.
- **Registered outputs.** `result`, `out_valid` and `busy` are registered. No combinational path runs from any input to any output except `in_ready`, which is a combinational function of state and `resetn`.

## Test plan
- **MUL.** a=3, b=0xFFFF_FFFF_FFFF_FFFB (−5) → `result` 0xFFFF_FFFF_FFFF_FFF1. `out_valid` after edge e+64; `busy` high for 65 cycles with `out_ready` tied high.
- **Signed and unsigned divide.**
  - DIV −7/2 → 0xFFFF_FFFF_FFFF_FFFD.
  - REM −7/2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVU 7/2 → 3.
  - REMU 7/2 → 1.
  - Each has `out_valid` after edge e+64.
- **Special cases.** Each has `out_valid` one cycle after accept and RUN is never entered.
  - DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF.
  - REMU 5/0 → 5.
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
  - `op`=12 → 0.
- **W ops.** Each has `out_valid` after edge e+32.
  - DIVW a=0x0000_0001_8000_0000, b=−1 → 0xFFFF_FFFF_8000_0000.
  - MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
  - DIVUW 0xFFFF_FFFE/1 → 0xFFFF_FFFF_FFFF_FFFE.
- **Backpressure.** Hold `out_ready` low for 10 cycles in DONE → `result` and `out_valid` stay stable, `in_ready` stays low, and `in_valid` is ignored. Then assert `out_ready` → IDLE next cycle, and a new op is accepted on the following edge.
- **Abort.**
  - `flush` at iteration 20 of a DIV → `out_valid` never rises and `in_ready` is high the next cycle.
  - `resetn` low mid-RUN → every output is at its reset value the next cycle, and a following MUL 3×4 → 12 completes normally.
